mmu_data_xlate: RTL and testbench

Data-side address translation stage between the memory pipeline stage and the shared TLB lookup array. It accepts one virtual-address request at a time and classifies its segment. Unmapped kseg0/kseg1 addresses, and mapped addresses that hit a one-entry micro-TLB, resolve in one cycle. Other mapped addresses go through a registered lookup in the TLB array. The block returns the physical address or an exception code plus BadVAddr to the memory stage and CP0.

---
 rtl/mmu_data_xlate_pkg.sv | 24 ++
 rtl/mmu_utlb_entry.sv | 52 +++++
 rtl/mmu_data_xlate.sv | 191 +++++++++++++++++++
 tb/tb_mmu_data_xlate.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mmu_data_xlate_pkg.sv
// Shared MMU definitions: exception codes, segment decode and the translation FSM encoding.
package mmu_data_xlate_pkg;

   localparam logic [2:0] EXC_NONE    = 3'd0;
   localparam logic [2:0] EXC_REFILL  = 3'd1;
   localparam logic [2:0] EXC_INVALID = 3'd2;
   localparam logic [2:0] EXC_MOD     = 3'd3;
   localparam logic [2:0] EXC_ADEL    = 3'd4;

   localparam logic [2:0] KSEG0 = 3'b100;
   localparam logic [2:0] KSEG1 = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2
   } xlate_state_e;

   // kseg0/kseg1 bypass translation and map straight onto the low 512 MB.
   function automatic logic seg_unmapped(input logic [2:0] seg);
      return (seg == KSEG0) || (seg == KSEG1);
   endfunction

endpackage

// File: rtl/mmu_utlb_entry.sv
// Single-entry micro-TLB: one cached VPN->PFN mapping tagged with ASID and dirty bit.
module mmu_utlb_entry #(
   parameter bit UTLB_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        fill,
   input  logic [19:0] fill_vpn,
   input  logic [19:0] fill_pfn,
   input  logic [7:0]  fill_asid,
   input  logic        fill_dirty,
   input  logic [19:0] look_vpn,
   input  logic [7:0]  look_asid,
   input  logic        look_we,
   output logic        hit,
   output logic [19:0] pfn
);

   logic        valid_r;
   logic [19:0] vpn_r;
   logic [19:0] pfn_r;
   logic [7:0]  asid_r;
   logic        dirty_r;

   // Entry storage; a flush wins over a fill on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         vpn_r   <= 20'd0;
         pfn_r   <= 20'd0;
         asid_r  <= 8'd0;
         dirty_r <= 1'b0;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (fill) begin
         valid_r <= UTLB_EN;
         vpn_r   <= fill_vpn;
         pfn_r   <= fill_pfn;
         asid_r  <= fill_asid;
         dirty_r <= fill_dirty;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Stores only hit a page already known to be dirty; otherwise the array must raise TLB Mod.
   assign hit = UTLB_EN && valid_r && (vpn_r == look_vpn) && (asid_r == look_asid)
                && (!look_we || dirty_r);
   assign pfn = pfn_r;

endmodule

// File: rtl/mmu_data_xlate.sv
// Data-side address translation: segment decode, micro-TLB fast path, registered TLB-array lookup.
module mmu_data_xlate
   import mmu_data_xlate_pkg::*;
#(
   parameter bit UTLB_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_vaddr,
   input  logic        req_we,
   input  logic        req_user,
   input  logic [7:0]  asid,
   input  logic        tlbwi_flush,
   output logic [31:0] tlb_vaddr,
   input  logic [31:0] tlb_paddr,
   input  logic        tlb_miss,
   input  logic        tlb_valid,
   input  logic        tlb_dirty,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_paddr,
   output logic [2:0]  resp_exc,
   output logic [31:0] resp_badvaddr
);

   xlate_state_e state_r;
   xlate_state_e state_s;

   logic        req_ready_r;
   logic        resp_valid_r;
   logic [31:0] resp_paddr_r;
   logic [2:0]  resp_exc_r;
   logic [31:0] resp_badvaddr_r;
   logic [31:0] tlb_vaddr_r;
   logic        req_we_r;

   logic [31:0] resp_paddr_s;
   logic [2:0]  resp_exc_s;
   logic [31:0] resp_badvaddr_s;
   logic [31:0] tlb_vaddr_s;
   logic        req_we_s;
   logic        fill_s;

   logic        accept_s;
   logic        adel_s;
   logic        unmapped_s;
   logic        utlb_hit_s;
   logic [19:0] utlb_pfn_s;

   assign accept_s   = req_valid && req_ready_r;
   assign adel_s     = req_user && req_vaddr[31];
   assign unmapped_s = seg_unmapped(req_vaddr[31:29]);

   mmu_utlb_entry #(.UTLB_EN(UTLB_EN)) u_utlb (
      .clk        (clk),
      .rst        (rst),
      .flush      (tlbwi_flush),
      .fill       (fill_s),
      .fill_vpn   (tlb_vaddr_r[31:12]),
      .fill_pfn   (tlb_paddr[31:12]),
      .fill_asid  (asid),
      .fill_dirty (tlb_dirty),
      .look_vpn   (req_vaddr[31:12]),
      .look_asid  (asid),
      .look_we    (req_we),
      .hit        (utlb_hit_s),
      .pfn        (utlb_pfn_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; a flush during LOOKUP forces a re-sample of the array.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!accept_s) begin
               state_s = ST_IDLE;
            end else if (adel_s || unmapped_s || utlb_hit_s) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (tlbwi_flush) begin
               state_s = ST_LOOKUP;
            end else begin
               state_s = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath next values: classification at acceptance, exception priority at lookup end.
   always_comb begin
      resp_paddr_s    = resp_paddr_r;
      resp_exc_s      = resp_exc_r;
      resp_badvaddr_s = resp_badvaddr_r;
      tlb_vaddr_s     = tlb_vaddr_r;
      req_we_s        = req_we_r;
      fill_s          = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               resp_badvaddr_s = req_vaddr;
               req_we_s        = req_we;
               resp_paddr_s    = 32'd0;
               resp_exc_s      = EXC_NONE;
               if (adel_s) begin
                  resp_exc_s = EXC_ADEL;
               end else if (unmapped_s) begin
                  resp_paddr_s = {3'b000, req_vaddr[28:0]};
               end else if (utlb_hit_s) begin
                  resp_paddr_s = {utlb_pfn_s, req_vaddr[11:0]};
               end else begin
                  tlb_vaddr_s = req_vaddr;
               end
            end else begin
               resp_exc_s = resp_exc_r;
            end
         end
         ST_LOOKUP: begin
            if (!tlbwi_flush) begin
               resp_paddr_s = 32'd0;
               if (tlb_miss) begin
                  resp_exc_s = EXC_REFILL;
               end else if (!tlb_valid) begin
                  resp_exc_s = EXC_INVALID;
               end else if (req_we_r && !tlb_dirty) begin
                  resp_exc_s = EXC_MOD;
               end else begin
                  resp_exc_s   = EXC_NONE;
                  resp_paddr_s = tlb_paddr;
                  fill_s       = 1'b1;
               end
            end else begin
               fill_s = 1'b0;
            end
         end
         ST_RESP: fill_s = 1'b0;
         default: fill_s = 1'b0;
      endcase
   end

   // Registered outputs and request context.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready_r     <= 1'b1;
         resp_valid_r    <= 1'b0;
         resp_paddr_r    <= 32'd0;
         resp_exc_r      <= EXC_NONE;
         resp_badvaddr_r <= 32'd0;
         tlb_vaddr_r     <= 32'd0;
         req_we_r        <= 1'b0;
      end else begin
         req_ready_r     <= (state_s == ST_IDLE);
         resp_valid_r    <= (state_s == ST_RESP);
         resp_paddr_r    <= resp_paddr_s;
         resp_exc_r      <= resp_exc_s;
         resp_badvaddr_r <= resp_badvaddr_s;
         tlb_vaddr_r     <= tlb_vaddr_s;
         req_we_r        <= req_we_s;
      end
   end

   assign req_ready     = req_ready_r;
   assign resp_valid    = resp_valid_r;
   assign resp_paddr    = resp_paddr_r;
   assign resp_exc      = resp_exc_r;
   assign resp_badvaddr = resp_badvaddr_r;
   assign tlb_vaddr     = tlb_vaddr_r;

endmodule

// File: tb/tb_mmu_data_xlate.sv
// Scoreboard bench for mmu_data_xlate with a behavioural single-page TLB array.
module tb_mmu_data_xlate;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_vaddr;
   logic        req_we;
   logic        req_user;
   logic [7:0]  asid;
   logic        tlbwi_flush;
   logic [31:0] tlb_vaddr;
   logic [31:0] tlb_paddr;
   logic        tlb_miss;
   logic        tlb_valid;
   logic        tlb_dirty;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_paddr;
   logic [2:0]  resp_exc;
   logic [31:0] resp_badvaddr;

   logic [19:0] tb_pfn;
   logic        alt_pend;
   logic        alt_miss;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] paddr;
      logic [2:0]  exc;
      logic [31:0] bad;
      int          lat;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   assign tlb_paddr = {tb_pfn, tlb_vaddr[11:0]};

   mmu_data_xlate #(.UTLB_EN(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_vaddr     (req_vaddr),
      .req_we        (req_we),
      .req_user      (req_user),
      .asid          (asid),
      .tlbwi_flush   (tlbwi_flush),
      .tlb_vaddr     (tlb_vaddr),
      .tlb_paddr     (tlb_paddr),
      .tlb_miss      (tlb_miss),
      .tlb_valid     (tlb_valid),
      .tlb_dirty     (tlb_dirty),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_paddr    (resp_paddr),
      .resp_exc      (resp_exc),
      .resp_badvaddr (resp_badvaddr)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic check_resp(input string tag, input exp_t e);
      check_eq({tag, "_exc"}, 32'(resp_exc), 32'(e.exc));
      check_eq({tag, "_bad"}, resp_badvaddr, e.bad);
      if (e.exc == 3'd0) check_eq({tag, "_paddr"}, resp_paddr, e.paddr);
   endtask

   // One request: push expectation, drive, wait (bounded) for the response, then drain it.
   task automatic run_req(input logic [31:0] va, input logic we, input logic user,
                          input logic [31:0] ep, input logic [2:0] ee, input int elat,
                          input int flush_at, input int hold);
      exp_t e;
      int   cyc;
      e.paddr = ep; e.exc = ee; e.bad = va; e.lat = elat;
      sb_q.push_back(e);
      @(negedge clk);
      check_eq("ready_idle", 32'(req_ready), 32'd1);
      req_vaddr = va; req_we = we; req_user = user; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0;
      while (cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (resp_valid) break;
         if (cyc == flush_at) begin
            tlbwi_flush = 1'b1;
         end else begin
            if (tlbwi_flush && alt_pend) begin
               tlb_miss = alt_miss;
               alt_pend = 1'b0;
            end
            tlbwi_flush = 1'b0;
         end
      end
      tlbwi_flush = 1'b0;
      e = sb_q.pop_front();
      check_eq("resp_valid", 32'(resp_valid), 32'd1);
      check_eq("latency", 32'(cyc), 32'(e.lat));
      check_resp("resp", e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_eq("hold_valid", 32'(resp_valid), 32'd1);
         check_eq("hold_ready", 32'(req_ready), 32'd0);
         check_resp("hold", e);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check_eq("resp_drop", 32'(resp_valid), 32'd0);
      check_eq("ready_back", 32'(req_ready), 32'd1);
      resp_ready = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      tlbwi_flush = 1'b1;
      @(negedge clk);
      tlbwi_flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_vaddr = 32'd0; req_we = 1'b0; req_user = 1'b0;
      asid = 8'd0; tlbwi_flush = 1'b0; resp_ready = 1'b0;
      tb_pfn = 20'h01234; tlb_miss = 1'b0; tlb_valid = 1'b1; tlb_dirty = 1'b0;
      alt_pend = 1'b0; alt_miss = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_paddr", resp_paddr, 32'd0);
      check_eq("rst_resp_exc", 32'(resp_exc), 32'd0);
      check_eq("rst_badvaddr", resp_badvaddr, 32'd0);
      check_eq("rst_tlb_vaddr", tlb_vaddr, 32'd0);
      rst = 1'b0;

      // Unmapped kernel segments and user address error.
      run_req(32'h8000_1234, 1'b0, 1'b0, 32'h0000_1234, 3'd0, 1, 0, 0);
      check_eq("kseg0_tlb_vaddr", tlb_vaddr, 32'd0);
      run_req(32'hBFC0_0100, 1'b0, 1'b0, 32'h1FC0_0100, 3'd0, 1, 0, 0);
      run_req(32'hA000_0000, 1'b0, 1'b1, 32'd0, 3'd4, 1, 0, 0);

      // Mapped load fills the micro-TLB; the repeat hits even though the array changed.
      run_req(32'h0040_0010, 1'b0, 1'b0, 32'h0123_4010, 3'd0, 2, 0, 0);
      check_eq("map_tlb_vaddr", tlb_vaddr, 32'h0040_0010);
      tb_pfn = 20'h0ABCD;
      run_req(32'h0040_0010, 1'b0, 1'b0, 32'h0123_4010, 3'd0, 1, 0, 0);
      run_req(32'h0040_0020, 1'b1, 1'b0, 32'd0, 3'd3, 2, 0, 0);

      // ASID change misses, refills under the new ASID; an idle flush then forces another lookup.
      asid = 8'h05;
      run_req(32'h0040_0010, 1'b0, 1'b0, 32'h0ABC_D010, 3'd0, 2, 0, 0);
      run_req(32'h0040_0018, 1'b0, 1'b0, 32'h0ABC_D018, 3'd0, 1, 0, 0);
      pulse_flush();
      run_req(32'h0040_0010, 1'b0, 1'b0, 32'h0ABC_D010, 3'd0, 2, 0, 0);

      // Refill exception does not fill, so the retry is still a lookup.
      tlb_miss = 1'b1;
      run_req(32'h7FFF_F000, 1'b0, 1'b0, 32'd0, 3'd1, 2, 0, 0);
      run_req(32'h7FFF_F000, 1'b0, 1'b0, 32'd0, 3'd1, 2, 0, 0);

      // Flush in LOOKUP: the fill-worthy sample is discarded and the re-sample misses.
      tlb_miss = 1'b0; tlb_dirty = 1'b1; tb_pfn = 20'h03333;
      alt_pend = 1'b1; alt_miss = 1'b1;
      run_req(32'h0080_0004, 1'b0, 1'b0, 32'd0, 3'd1, 3, 1, 0);
      run_req(32'h0080_0004, 1'b0, 1'b0, 32'd0, 3'd1, 2, 0, 0);
      tlb_miss = 1'b0; tlb_valid = 1'b0;
      run_req(32'h0080_0008, 1'b0, 1'b0, 32'd0, 3'd2, 2, 0, 0);
      tlb_valid = 1'b1;
      run_req(32'h0080_0008, 1'b1, 1'b0, 32'h0333_3008, 3'd0, 2, 0, 0);
      run_req(32'h0080_000C, 1'b1, 1'b0, 32'h0333_300C, 3'd0, 1, 0, 0);

      // Back-pressure: response held 3 cycles.
      run_req(32'h8000_0040, 1'b0, 1'b0, 32'h0000_0040, 3'd0, 1, 0, 3);

      // Reset in the middle of a lookup drops the request.
      tb_pfn = 20'h04444;
      @(negedge clk);
      req_vaddr = 32'h0090_0000; req_we = 1'b0; req_user = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check_eq("lookup_no_valid", 32'(resp_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_valid", 32'(resp_valid), 32'd0);
      check_eq("abort_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_quiet", 32'(resp_valid), 32'd0);

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
